// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, writeback-source encoding and stage-register layout for the MEM/WB stage.
package mem_wb_stage_pkg;

  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic                  wb_valid;
    logic                  wb_reg_write;
    wb_src_e               wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_alu;
    logic [DATA_W-1:0]     wb_mem;
  } wb_slot_t;

  function automatic logic [DATA_W-1:0] wb_select(
    input wb_src_e           src,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem
  );
    return (src == WB_SRC_MEM) ? mem : alu;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundles the memory-stage slot, pipeline controls, register-file write port,
// forwarding tap, retire counter and read-bypass signals of the MEM/WB stage.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic                  m_valid;
  logic                  m_reg_write;
  logic                  m_mem_to_reg;
  logic [REG_ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0]     m_alu_result;
  logic [DATA_W-1:0]     m_mem_data;
  logic                  stall;
  logic                  flush;

  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]     write_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;
  logic [DATA_W-1:0]     retire_count;

  logic [REG_ADDR_W-1:0] rd_addr1;
  logic [REG_ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0]     rf_data1;
  logic [DATA_W-1:0]     rf_data2;
  logic [DATA_W-1:0]     bp_data1;
  logic [DATA_W-1:0]     bp_data2;

  // No handshake: the m_* slot is accepted every edge unless stall holds it or flush squashes it.
  modport slave (
    input  m_valid, m_reg_write, m_mem_to_reg, m_rd, m_alu_result, m_mem_data,
    input  stall, flush,
    input  rd_addr1, rd_addr2, rf_data1, rf_data2,
    output write_enable, write_addr, write_data,
    output fwd_valid, fwd_addr, fwd_data, retire_count,
    output bp_data1, bp_data2
  );

  modport master (
    output m_valid, m_reg_write, m_mem_to_reg, m_rd, m_alu_result, m_mem_data,
    output stall, flush,
    output rd_addr1, rd_addr2, rf_data1, rf_data2,
    input  write_enable, write_addr, write_data,
    input  fwd_valid, fwd_addr, fwd_data, retire_count,
    input  bp_data1, bp_data2
  );

endinterface

// File: rtl/mem_wb_stage_wb_bypass_mux.sv
// Single read-port bypass: returns the in-flight writeback value when it targets the read address.
module wb_bypass_mux
  import mem_wb_stage_pkg::*;
(
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0]     rf_data_i,
  output logic [DATA_W-1:0]     bp_data_o
);

  logic hit;

  assign hit       = we_i && (rd_addr_i == wr_addr_i);
  assign bp_data_o = hit ? wr_data_i : rf_data_i;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with register-file write port, forwarding tap and retire counter.
// Optional read bypass of the writeback value is built when WB_BYPASS_EN is defined.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  wb_slot_t          slot_q, slot_d;
  logic [DATA_W-1:0] retire_q, retire_d;
  wb_slot_t          incoming;
  logic              slot_leaves;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    incoming               = '0;
    incoming.wb_valid      = bus.m_valid;
    incoming.wb_reg_write  = bus.m_reg_write;
    incoming.wb_mem_to_reg = wb_src_e'(bus.m_mem_to_reg);
    incoming.wb_rd         = bus.m_rd;
    incoming.wb_alu        = bus.m_alu_result;
    incoming.wb_mem        = bus.m_mem_data;
  end

  // The WB slot leaves the stage whenever it is not held; flush overrides a stall,
  // so a flush+stall edge also retires the instruction sitting in WB.
  assign slot_leaves = slot_q.wb_valid && (!bus.stall || bus.flush);

  always_comb begin
    slot_d   = slot_q;
    retire_d = retire_q;
    if (bus.flush) begin
      slot_d.wb_valid = 1'b0;
    end else if (!bus.stall) begin
      slot_d = incoming;
    end
    if (slot_leaves) begin
      retire_d = retire_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q   <= '0;
      retire_q <= '0;
    end else begin
      slot_q   <= slot_d;
      retire_q <= retire_d;
    end
  end

  assign wr_en   = slot_q.wb_valid && slot_q.wb_reg_write;
  assign wr_data = wb_select(slot_q.wb_mem_to_reg, slot_q.wb_alu, slot_q.wb_mem);

  assign bus.write_enable = wr_en;
  assign bus.write_addr   = slot_q.wb_rd;
  assign bus.write_data   = wr_data;
  assign bus.fwd_valid    = wr_en;
  assign bus.fwd_addr     = slot_q.wb_rd;
  assign bus.fwd_data     = wr_data;
  assign bus.retire_count = retire_q;

`ifdef WB_BYPASS_EN
  wb_bypass_mux u_bypass1 (
    .we_i      (wr_en),
    .wr_addr_i (slot_q.wb_rd),
    .wr_data_i (wr_data),
    .rd_addr_i (bus.rd_addr1),
    .rf_data_i (bus.rf_data1),
    .bp_data_o (bus.bp_data1)
  );

  wb_bypass_mux u_bypass2 (
    .we_i      (wr_en),
    .wr_addr_i (slot_q.wb_rd),
    .wr_data_i (wr_data),
    .rd_addr_i (bus.rd_addr2),
    .rf_data_i (bus.rf_data2),
    .bp_data_o (bus.bp_data2)
  );
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^{bus.rd_addr1, bus.rd_addr2};
  assign bus.bp_data1   = bus.rf_data1;
  assign bus.bp_data2   = bus.rf_data2;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slot(input logic v, input logic rw, input logic mtr,
                            input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] mem);
    bus.m_valid      = v;
    bus.m_reg_write  = rw;
    bus.m_mem_to_reg = mtr;
    bus.m_rd         = rd;
    bus.m_alu_result = alu;
    bus.m_mem_data   = mem;
  endtask

  task automatic check_wport(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
    check({tag, "_we"},   32'(bus.write_enable), 32'(we));
    check({tag, "_addr"}, 32'(bus.write_addr),   32'(a));
    check({tag, "_data"}, 32'(bus.write_data),   32'(d));
    check({tag, "_fwdv"}, 32'(bus.fwd_valid),    32'(we));
    check({tag, "_fwda"}, 32'(bus.fwd_addr),     32'(a));
    check({tag, "_fwdd"}, 32'(bus.fwd_data),     32'(d));
  endtask

  logic [15:0] exp_bp1;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.rd_addr1 = 3'd0;
    bus.rd_addr2 = 3'd0;
    bus.rf_data1 = 16'h0;
    bus.rf_data2 = 16'h0;
    drive_slot(1'b1, 1'b1, 1'b0, 3'd7, 16'hFFFF, 16'hEEEE);

    // Reset held two cycles with a valid slot on the inputs.
    step();
    step();
    check_wport("reset", 1'b0, 3'd0, 16'h0000);
    check("reset_retire", 32'(bus.retire_count), 32'd0);

    // ALU path.
    rst = 1'b1;
    drive_slot(1'b1, 1'b1, 1'b0, 3'd5, 16'h1234, 16'h5555);
    step();
    check_wport("alu", 1'b1, 3'd5, 16'h1234);
    check("alu_retire0", 32'(bus.retire_count), 32'd0);

    // MEM path, then three stalled cycles with different inputs.
    drive_slot(1'b1, 1'b1, 1'b1, 3'd2, 16'h0F0F, 16'hBEEF);
    step();
    check_wport("mem", 1'b1, 3'd2, 16'hBEEF);
    check("alu_retire1", 32'(bus.retire_count), 32'd1);
    bus.stall = 1'b1;
    drive_slot(1'b1, 1'b1, 1'b0, 3'd6, 16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      step();
      check_wport("stall_hold", 1'b1, 3'd2, 16'hBEEF);
      check("stall_retire", 32'(bus.retire_count), 32'd1);
    end
    bus.stall = 1'b0;
    step();
    check_wport("stall_release", 1'b1, 3'd6, 16'h1111);
    check("release_retire", 32'(bus.retire_count), 32'd2);

    // Flush and stall together: incoming squashed, WB instruction still counted.
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    drive_slot(1'b1, 1'b1, 1'b0, 3'd1, 16'h7777, 16'h0000);
    step();
    check("flush_stall_we", 32'(bus.write_enable), 32'd0);
    check("flush_stall_fwdv", 32'(bus.fwd_valid), 32'd0);
    check("flush_stall_retire", 32'(bus.retire_count), 32'd3);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive_slot(1'b0, 1'b1, 1'b0, 3'd1, 16'h7777, 16'h0000);
    step();
    check("bubble_we", 32'(bus.write_enable), 32'd0);
    check("bubble_retire", 32'(bus.retire_count), 32'd3);

    // Valid slot without register write retires but does not write.
    drive_slot(1'b1, 1'b0, 1'b0, 3'd3, 16'hAAAA, 16'h0000);
    step();
    check("norw_we", 32'(bus.write_enable), 32'd0);
    check("norw_retire", 32'(bus.retire_count), 32'd3);
    bus.rd_addr1 = 3'd3;
    bus.rd_addr2 = 3'd4;
    bus.rf_data1 = 16'h0011;
    bus.rf_data2 = 16'h0022;
    #1;
    check("norw_bp1", 32'(bus.bp_data1), 32'h0011);

    // Register 0 is written like any other.
    drive_slot(1'b1, 1'b1, 1'b0, 3'd0, 16'h00F0, 16'h0000);
    step();
    check_wport("reg0", 1'b1, 3'd0, 16'h00F0);
    check("reg0_retire", 32'(bus.retire_count), 32'd4);

    // Read bypass of write to r3.
    drive_slot(1'b1, 1'b1, 1'b0, 3'd3, 16'h00AA, 16'h0000);
    step();
    check_wport("bp_src", 1'b1, 3'd3, 16'h00AA);
`ifdef WB_BYPASS_EN
    exp_bp1 = 16'h00AA;
`else
    exp_bp1 = 16'h0011;
`endif
    check("bp1", 32'(bus.bp_data1), 32'(exp_bp1));
    check("bp2", 32'(bus.bp_data2), 32'h0022);
    check("bp_retire", 32'(bus.retire_count), 32'd5);

    // Reset mid-operation beats stall and flush.
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    rst = 1'b0;
    step();
    check_wport("midreset", 1'b0, 3'd0, 16'h0000);
    check("midreset_retire", 32'(bus.retire_count), 32'd0);

    // Counter wrap: first edge only fills WB, then each edge retires one.
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive_slot(1'b1, 1'b1, 1'b0, 3'd4, 16'h0001, 16'h0000);
    repeat (65536) @(posedge clk);
    #1;
    check("wrap_pre", 32'(bus.retire_count), 32'h0000FFFF);
    step();
    check("wrap_post", 32'(bus.retire_count), 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
